odd_even_sorter: RTL and testbench
==================================

# odd_even_sorter

Sequential odd-even transposition sorter: accepts one vector of `LANES` unsigned values, each with an index tag. It sorts the vector in place over `LANES` clock cycles, one compare-exchange phase per cycle, then presents the sorted values and their tags on a valid/ready output. It is the parametrised, time-multiplexed successor to the combinational compare-exchange element in the sorting network. It adds lane-count generality, run-time ascending/descending selection and handshaked flow control, and it serves the symbol-ranking path where a full combinational network is too large.

## Interface
- `NETWORK_WIDTH`, default 16: bit width of each value.
- `INDEX_WIDTH`, default 3: bit width of each index tag.
- `LANES`, default 8: number of values per vector. Legal range is ≥2 (odd values allowed).

- `clk`  in  1: single clock, rising edge.
- `rst_n`  in  1: reset, synchronous, active-low.
- `in_valid`  in  1: input vector valid.
- `in_ready`  out  1: block can accept a vector.
- `in_data`  in  LANES*NETWORK_WIDTH: lane i at `[i*NETWORK_WIDTH +: NETWORK_WIDTH]`.
- `in_index`  in  LANES*INDEX_WIDTH: lane i tag at `[i*INDEX_WIDTH +: INDEX_WIDTH]`.
- `in_descending`  in  1: sort direction; 0 = ascending, 1 = descending. Sampled only on accept.
- `out_valid`  out  1: sorted vector valid.
- `out_ready`  in  1: downstream accepts.
- `out_data`  out  LANES*NETWORK_WIDTH: sorted values, same lane packing as `in_data`.
- `out_index`  out  LANES*INDEX_WIDTH: tags that travelled with their values.

## Operation
- FSM states are IDLE, SORT and DONE.
- IDLE:
  - `in_ready`=1.
  - On `in_valid && in_ready`, capture `in_data`, `in_index` and `in_descending` into lane registers, clear the phase counter and go to SORT.
- SORT:
  - `in_ready`=0 and `out_valid`=0.
  - Each cycle applies phase p, where p is the counter value 0..LANES-1.
  - Even p compares lane pairs (0,1),(2,3),…; odd p compares (1,2),(3,4),….
  - An unpaired edge lane passes through unchanged.
  - When the counter equals LANES-1, go to DONE after that phase.
- Compare-exchange on pair (lo,hi), using unsigned comparison:
  - Ascending: swap only if `v[lo] > v[hi]`.
  - Descending: swap only if `v[lo] < v[hi]`.
  - Equal values never swap, so the sort is stable.
  - The index tag always moves with its value.
- DONE:
  - `out_valid`=1.
  - `out_data`/`out_index` come directly from the lane registers and are held stable until `out_ready`.
  - On `out_valid && out_ready`, go to IDLE.
- `in_valid` while `in_ready`=0 is ignored; upstream must hold its data. `out_ready` without `out_valid` has no effect.
- Phase counter width is clog2(LANES). It never wraps within a sort.

## Timing
- Reset is synchronous: while `rst_n`=0 at a rising edge, the block enters IDLE and clears the lane registers and counter.
- Reset values of the outputs:
  - `in_ready`=0 while `rst_n` is low, 1 from the first cycle after release.
  - `out_valid`=0.
  - `out_data`=0 and `out_index`=0.
- Accept edge E0: phases execute on edges E1..E_LANES, and `out_valid` is high in the cycle after E_LANES. Latency is LANES cycles.
- The earliest output handshake is E_LANES+1. IDLE is re-entered and `in_ready` rises after that edge.
- Maximum throughput is one vector per LANES+2 cycles, with no overlap of input and output.
- Reset asserted mid-SORT or in DONE abandons the vector: no `out_valid` is produced and the block is in IDLE after release.
- All outputs are registered or decoded from registered state. There are no combinational paths from `in_*` to `out_*`.

## Test plan
- **Ascending sort, LANES=8, NETWORK_WIDTH=16.**
  - Stimulus: data {7,3,9,1,8,2,6,0} (lane0..7), indices {0..7}, `in_descending`=0.
  - Required response: out_data {0,1,2,3,6,7,8,9}, out_index {7,3,5,1,6,0,4,2}, `out_valid` exactly 8 cycles after accept.
- **Descending sort, same vector.**
  - Stimulus: as above with `in_descending`=1.
  - Required response: out_data {9,8,7,6,3,2,1,0}, out_index {2,4,0,6,1,5,3,7}.
- **Ties (stability).**
  - Stimulus: all lanes value 5, indices {0..7}, run once per direction.
  - Required response: out_index {0..7} unchanged in both directions.
- **Output backpressure.**
  - Stimulus: hold `out_ready`=0 for 10 cycles after `out_valid`, pulsing `in_valid` with a new vector.
  - Required response: outputs stable, `in_ready`=0 and the new vector not accepted. After `out_ready`=1 for one cycle, `out_valid`=0 and `in_ready`=1 on the next cycle.
- **Reset mid-sort.**
  - Stimulus: drive `rst_n`=0 for one edge at phase 3, then release and send {4,1,3,2,…}.
  - Required response: no `out_valid` for the abandoned vector, `out_data`=0 after reset, and the second vector sorts correctly.
- **Odd lane count, full-scale value.**
  - Stimulus: instance with LANES=5, INDEX_WIDTH=3; data {16'hFFFF,4,3,2,0}, indices {0..4}, ascending.
  - Required response: out_data {0,2,3,4,16'hFFFF}, out_index {4,3,2,1,0}, latency 5.

Source files
------------

// File: rtl/odd_even_sorter.sv
// Time-multiplexed odd-even transposition sorter: one compare-exchange phase per
// cycle over LANES lane registers, index tags travel with their values.
module odd_even_sorter #(
  parameter int unsigned NETWORK_WIDTH = 16,
  parameter int unsigned INDEX_WIDTH   = 3,
  parameter int unsigned LANES         = 8
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [LANES*NETWORK_WIDTH-1:0] in_data,
  input  logic [LANES*INDEX_WIDTH-1:0]   in_index,
  input  logic                           in_descending,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [LANES*NETWORK_WIDTH-1:0] out_data,
  output logic [LANES*INDEX_WIDTH-1:0]   out_index
);

  localparam int unsigned PW = (LANES > 2) ? $clog2(LANES) : 1;
  localparam logic [PW-1:0] LAST_PHASE = PW'(LANES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SORT = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                   r_state;
  logic [PW-1:0]            r_phase;
  logic                     r_desc;
  logic                     r_in_ready;
  logic                     r_out_valid;
  logic [NETWORK_WIDTH-1:0] r_data  [LANES];
  logic [INDEX_WIDTH-1:0]   r_index [LANES];
  logic [NETWORK_WIDTH-1:0] w_data  [LANES];
  logic [INDEX_WIDTH-1:0]   w_index [LANES];

  // One transposition phase: even phases pair (0,1),(2,3)..., odd phases (1,2),(3,4)...
  always_comb begin
    w_data  = r_data;
    w_index = r_index;
    for (int i = 0; i < int'(LANES) - 1; i++) begin
      if (i[0] == r_phase[0]) begin
        if (r_desc ? (r_data[i] < r_data[i+1]) : (r_data[i] > r_data[i+1])) begin
          w_data[i]    = r_data[i+1];
          w_data[i+1]  = r_data[i];
          w_index[i]   = r_index[i+1];
          w_index[i+1] = r_index[i];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_phase     <= '0;
      r_desc      <= 1'b0;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      for (int i = 0; i < int'(LANES); i++) begin
        r_data[i]  <= '0;
        r_index[i] <= '0;
      end
    end else begin
      case (r_state)
        IDLE: begin
          r_in_ready <= 1'b1;
          if (in_valid && r_in_ready) begin
            for (int i = 0; i < int'(LANES); i++) begin
              r_data[i]  <= in_data[i*NETWORK_WIDTH +: NETWORK_WIDTH];
              r_index[i] <= in_index[i*INDEX_WIDTH +: INDEX_WIDTH];
            end
            r_desc     <= in_descending;
            r_phase    <= '0;
            r_in_ready <= 1'b0;
            r_state    <= SORT;
          end
        end
        SORT: begin
          r_data  <= w_data;
          r_index <= w_index;
          if (r_phase == LAST_PHASE) begin
            r_out_valid <= 1'b1;
            r_state     <= DONE;
          end else begin
            r_phase <= r_phase + PW'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= IDLE;
          end
        end
        default: begin
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b0;
          r_state     <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;

  for (genvar g = 0; g < int'(LANES); g++) begin : g_pack
    assign out_data[g*NETWORK_WIDTH +: NETWORK_WIDTH] = r_data[g];
    assign out_index[g*INDEX_WIDTH +: INDEX_WIDTH]    = r_index[g];
  end

endmodule

// File: tb/tb_odd_even_sorter.sv
// Bench for odd_even_sorter: 8-lane and 5-lane instances against a stable
// insertion-sort reference model.
module tb_odd_even_sorter;

  localparam int unsigned W  = 16;
  localparam int unsigned IW = 3;
  localparam int unsigned LA = 8;
  localparam int unsigned LB = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic              a_in_valid, a_in_ready, a_in_desc, a_out_valid, a_out_ready;
  logic [LA*W-1:0]   a_in_data, a_out_data;
  logic [LA*IW-1:0]  a_in_index, a_out_index;
  logic              b_in_valid, b_in_ready, b_in_desc, b_out_valid, b_out_ready;
  logic [LB*W-1:0]   b_in_data, b_out_data;
  logic [LB*IW-1:0]  b_in_index, b_out_index;

  odd_even_sorter #(.NETWORK_WIDTH(W), .INDEX_WIDTH(IW), .LANES(LA)) u_dut_a (
    .clk(clk), .rst_n(rst_n),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
    .in_index(a_in_index), .in_descending(a_in_desc),
    .out_valid(a_out_valid), .out_ready(a_out_ready),
    .out_data(a_out_data), .out_index(a_out_index)
  );

  odd_even_sorter #(.NETWORK_WIDTH(W), .INDEX_WIDTH(IW), .LANES(LB)) u_dut_b (
    .clk(clk), .rst_n(rst_n),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
    .in_index(b_in_index), .in_descending(b_in_desc),
    .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_data(b_out_data), .out_index(b_out_index)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: stable insertion sort; strict ordering keeps equal values in arrival order.
  function automatic void model(input int unsigned v[8], input int unsigned ix[8], input int n,
                                input bit desc, output logic [127:0] ed, output logic [127:0] ei);
    int unsigned sv[8];
    int unsigned si[8];
    int unsigned t;
    sv = v;
    si = ix;
    for (int i = 1; i < n; i++) begin
      for (int j = i; j > 0; j--) begin
        if (desc ? (sv[j] > sv[j-1]) : (sv[j] < sv[j-1])) begin
          t = sv[j]; sv[j] = sv[j-1]; sv[j-1] = t;
          t = si[j]; si[j] = si[j-1]; si[j-1] = t;
        end
      end
    end
    ed = '0;
    ei = '0;
    for (int i = 0; i < n; i++) begin
      ed[i*W +: W]   = W'(sv[i]);
      ei[i*IW +: IW] = IW'(si[i]);
    end
  endfunction

  function automatic logic [127:0] sel_val(input bit sel_b, input logic [127:0] a, input logic [127:0] b);
    return sel_b ? b : a;
  endfunction

  // Send one vector, measure latency, compare output, optionally hold backpressure, then handshake.
  task automatic run(input bit sel_b, input int unsigned v[8], input int unsigned ix[8],
                     input bit desc, input int hold, input string tag);
    int          n;
    int          lat;
    logic [127:0] ed, ei, pd, pi;
    logic         ir, ov;
    n = sel_b ? int'(LB) : int'(LA);
    model(v, ix, n, desc, ed, ei);
    pd = '0;
    pi = '0;
    for (int i = 0; i < n; i++) begin
      pd[i*W +: W]   = W'(v[i]);
      pi[i*IW +: IW] = IW'(ix[i]);
    end
    @(negedge clk);
    ir = 1'b0;
    for (int k = 0; k < 50 && !ir; k++) begin
      ir = sel_b ? b_in_ready : a_in_ready;
      if (!ir) @(negedge clk);
    end
    check({tag, "_ready"}, 128'(ir), 128'(1));
    if (sel_b) begin
      b_in_data = pd[LB*W-1:0]; b_in_index = pi[LB*IW-1:0]; b_in_desc = desc; b_in_valid = 1'b1;
    end else begin
      a_in_data = pd[LA*W-1:0]; a_in_index = pi[LA*IW-1:0]; a_in_desc = desc; a_in_valid = 1'b1;
    end
    @(posedge clk);
    @(negedge clk);
    a_in_valid = 1'b0;
    b_in_valid = 1'b0;
    lat = 0;
    ov  = 1'b0;
    while (!ov && lat < 40) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      ov = sel_b ? b_out_valid : a_out_valid;
    end
    check({tag, "_latency"}, 128'(lat), 128'(n));
    check({tag, "_data"}, sel_val(sel_b, 128'(a_out_data), 128'(b_out_data)), ed);
    check({tag, "_index"}, sel_val(sel_b, 128'(a_out_index), 128'(b_out_index)), ei);
    for (int k = 0; k < hold; k++) begin
      a_in_valid = k[0];
      a_in_data  = ~pd[LA*W-1:0];
      @(posedge clk);
      @(negedge clk);
      check({tag, "_bp_valid"}, 128'(a_out_valid), 128'(1));
      check({tag, "_bp_ready"}, 128'(a_in_ready), 128'(0));
      check({tag, "_bp_data"}, 128'(a_out_data), ed);
      check({tag, "_bp_index"}, 128'(a_out_index), ei);
    end
    a_in_valid = 1'b0;
    if (sel_b) b_out_ready = 1'b1; else a_out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    a_out_ready = 1'b0;
    b_out_ready = 1'b0;
    check({tag, "_post_valid"}, sel_val(sel_b, 128'(a_out_valid), 128'(b_out_valid)), 128'(0));
    check({tag, "_post_ready"}, sel_val(sel_b, 128'(a_in_ready), 128'(b_in_ready)), 128'(1));
    if (hold > 0) begin
      repeat (3) @(posedge clk);
      @(negedge clk);
      check({tag, "_not_accepted"}, {126'd0, a_out_valid, a_in_ready}, 128'(1));
    end
  endtask

  initial begin
    int unsigned v[8];
    int unsigned ix[8];
    int unsigned seq[8];
    bit          seen;
    logic [127:0] pd;

    rst_n = 1'b0;
    a_in_valid = 1'b0; a_in_desc = 1'b0; a_out_ready = 1'b0; a_in_data = '0; a_in_index = '0;
    b_in_valid = 1'b0; b_in_desc = 1'b0; b_out_ready = 1'b0; b_in_data = '0; b_in_index = '0;
    seq = '{0, 1, 2, 3, 4, 5, 6, 7};

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_a_ready", 128'(a_in_ready), 128'(0));
    check("rst_a_valid", 128'(a_out_valid), 128'(0));
    check("rst_a_data", 128'(a_out_data), 128'(0));
    check("rst_a_index", 128'(a_out_index), 128'(0));
    check("rst_b_state", {b_in_ready, b_out_valid, 128'(b_out_data) != 0}, 128'(0));
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("release_ready", {126'd0, a_in_ready, b_in_ready}, 128'(3));

    v = '{7, 3, 9, 1, 8, 2, 6, 0};
    run(1'b0, v, seq, 1'b0, 0, "asc");
    run(1'b0, v, seq, 1'b1, 0, "desc");
    v = '{5, 5, 5, 5, 5, 5, 5, 5};
    run(1'b0, v, seq, 1'b0, 0, "tie_asc");
    run(1'b0, v, seq, 1'b1, 0, "tie_desc");
    v = '{12, 0, 65535, 3, 3, 40000, 1, 7};
    run(1'b0, v, seq, 1'b0, 10, "backpressure");

    // Reset asserted on the edge that would execute phase 3.
    v  = '{9, 8, 7, 6, 5, 4, 3, 2};
    pd = '0;
    for (int i = 0; i < 8; i++) pd[i*W +: W] = W'(v[i]);
    @(negedge clk);
    a_in_data = pd[LA*W-1:0]; a_in_index = '1; a_in_desc = 1'b0; a_in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    a_in_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    check("midrst_valid", 128'(a_out_valid), 128'(0));
    check("midrst_data", 128'(a_out_data), 128'(0));
    check("midrst_index", 128'(a_out_index), 128'(0));
    check("midrst_ready", 128'(a_in_ready), 128'(0));
    seen = 1'b0;
    repeat (12) begin
      @(posedge clk);
      @(negedge clk);
      if (a_out_valid) seen = 1'b1;
    end
    check("midrst_no_output", 128'(seen), 128'(0));
    v = '{4, 1, 3, 2, 8, 7, 6, 5};
    run(1'b0, v, seq, 1'b0, 0, "after_rst");

    v = '{65535, 4, 3, 2, 0, 0, 0, 0};
    run(1'b1, v, seq, 1'b0, 0, "odd5");

    for (int r = 0; r < 16; r++) begin
      for (int i = 0; i < 8; i++) begin
        v[i]  = r[0] ? $urandom_range(0, 7) : ($urandom & 32'hFFFF);
        ix[i] = $urandom_range(0, 7);
      end
      run(r[1], v, ix, 1'($urandom_range(0, 1)), 0, r[1] ? "rand_b" : "rand_a");
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
